ps2_key_receiver: RTL

- Upstream stage for every keyboard consumer (splash/Konami detector, game screens).
- Deserializes PS/2 device-to-host frames from the keyboard.
- Validates framing and parity, and strips E0/F0 prefix bytes.
- Presents each make code on Key for exactly one Clock cycle and 8'h00 otherwise, so consumers can compare Key every cycle without double-counting presses or releases.

---
 rtl/ps2_key_receiver.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 device-to-host keyboard receiver.
// Synchronizes and glitch-filters PS2_CLK/PS2_DAT, deserializes 11-bit frames,
// checks start/parity/stop, strips E0/F0 prefixes and emits one-cycle codes.
// Ports:
//   Clock    - system clock
//   Reset    - asynchronous active-low reset
//   PS2_CLK  - keyboard clock (asynchronous)
//   PS2_DAT  - keyboard data (asynchronous)
//   Key      - make code for one cycle, 8'h00 otherwise
//   KeyUp    - release code for one cycle, 8'h00 otherwise
//   Extended - high with a nonzero Key/KeyUp that was E0-prefixed
//   Error    - one-cycle pulse on framing/parity error, timeout or 00/FF code
module ps2_key_receiver #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] Key,
   output logic [7:0] KeyUp,
   output logic       Extended,
   output logic       Error
);

   localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_e;
   typedef enum logic {D_NORMAL, D_GOT_F0} dec_state_e;

   logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic filt_q;
   logic [FW-1:0] filt_cnt_q;
   logic filt_accept_c, sample_c;

   frame_state_e state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          byte_vld_q, byte_vld_d;
   logic          frame_err_q, frame_err_d;
   logic          abort_q, abort_d;

   dec_state_e dec_q, dec_d;
   logic       ext_q, ext_d;
   logic [7:0] key_q, key_d, keyup_q, keyup_d;
   logic       extended_q, extended_d, error_q, error_d;

   // Two-flop synchronizers; idle bus level is high.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= PS2_CLK;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= PS2_DAT;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Accept a new clock level once it has differed for FILTER_LEN cycles in a row.
   assign filt_accept_c = (clk_s2_q != filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
   assign sample_c      = filt_accept_c && filt_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
      end else if (clk_s2_q == filt_q) begin
         filt_cnt_q <= '0;
      end else if (filt_accept_c) begin
         filt_q     <= clk_s2_q;
         filt_cnt_q <= '0;
      end else begin
         filt_cnt_q <= filt_cnt_q + FW'(1);
      end
   end

   // Frame FSM: one step per sample event, plus mid-frame inactivity timeout.
   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      shreg_d     = shreg_q;
      par_d       = par_q;
      to_cnt_d    = '0;
      byte_vld_d  = 1'b0;
      frame_err_d = 1'b0;
      abort_d     = 1'b0;
      if (state_q != S_IDLE) begin
         to_cnt_d = sample_c ? '0 : to_cnt_q + TW'(1);
      end
      unique case (state_q)
         S_IDLE: begin
            // A high start bit is a spurious edge and is silently ignored.
            if (sample_c && !dat_s2_q) begin
               state_d  = S_DATA;
               bitcnt_d = '0;
            end
         end
         S_DATA: begin
            if (sample_c) begin
               shreg_d  = {dat_s2_q, shreg_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (sample_c) begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (sample_c) begin
               if (dat_s2_q && (^{shreg_q, par_q})) byte_vld_d  = 1'b1;
               else                                 frame_err_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if ((state_q != S_IDLE) && !sample_c && (to_cnt_q == TW'(TIMEOUT - 1))) begin
         state_d     = S_IDLE;
         to_cnt_d    = '0;
         frame_err_d = 1'b1;
         abort_d     = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= S_IDLE;
         bitcnt_q    <= '0;
         shreg_q     <= '0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shreg_q     <= shreg_d;
         par_q       <= par_d;
         to_cnt_q    <= to_cnt_d;
         byte_vld_q  <= byte_vld_d;
         frame_err_q <= frame_err_d;
         abort_q     <= abort_d;
      end
   end

   // Decoder: shreg_q still holds the byte while byte_vld_q is high (FSM is idle).
   always_comb begin
      dec_d      = dec_q;
      ext_d      = ext_q;
      key_d      = 8'h00;
      keyup_d    = 8'h00;
      extended_d = 1'b0;
      error_d    = 1'b0;
      if (frame_err_q) begin
         error_d = 1'b1;
         if (abort_q) begin
            dec_d = D_NORMAL;
            ext_d = 1'b0;
         end
      end else if (byte_vld_q) begin
         if (shreg_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shreg_q == 8'hF0) begin
            dec_d = D_GOT_F0;
         end else if ((shreg_q == 8'h00) || (shreg_q == 8'hFF)) begin
            error_d = 1'b1;
            dec_d   = D_NORMAL;
            ext_d   = 1'b0;
         end else begin
            if (dec_q == D_GOT_F0) keyup_d = shreg_q;
            else                   key_d   = shreg_q;
            extended_d = ext_q;
            ext_d      = 1'b0;
            dec_d      = D_NORMAL;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         dec_q      <= D_NORMAL;
         ext_q      <= 1'b0;
         key_q      <= 8'h00;
         keyup_q    <= 8'h00;
         extended_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         dec_q      <= dec_d;
         ext_q      <= ext_d;
         key_q      <= key_d;
         keyup_q    <= keyup_d;
         extended_q <= extended_d;
         error_q    <= error_d;
      end
   end

   assign Key      = key_q;
   assign KeyUp    = keyup_q;
   assign Extended = extended_q;
   assign Error    = error_q;

endmodule
